// File: rtl/uart_loader.sv
// Frame loader: parses SYNC/ADDR/CNT/DATA/CHK byte frames from a UART receiver
// and writes packed 32-bit little-endian words to RAM. core_go follows a good checksum.
module uart_loader #(
  parameter int          CLK_FREQ   = 60000000,
  parameter int          TIMEOUT_US = 1000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [12:0] ram_addres,
  output logic [31:0] data_to_mem,
  output logic        ram_we,
  output logic        busy,
  output logic        core_go,
  output logic        err
);

  localparam int TIMEOUT_CYC = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int GW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, CHECK
  } state_t;

  state_t        state;
  logic [7:0]    chk;
  logic [7:0]    addr_lo;
  logic [7:0]    cnt_lo;
  logic [12:0]   wr_addr;
  logic [15:0]   words_left;
  logic [1:0]    byte_idx;
  logic [23:0]   partial;
  logic [GW-1:0] gap_cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      chk         <= 8'h00;
      addr_lo     <= 8'h00;
      cnt_lo      <= 8'h00;
      wr_addr     <= 13'h0000;
      words_left  <= 16'h0000;
      byte_idx    <= 2'd0;
      partial     <= 24'h000000;
      gap_cnt     <= '0;
      ram_addres  <= 13'h0000;
      data_to_mem <= 32'h00000000;
      ram_we      <= 1'b0;
      core_go     <= 1'b0;
      err         <= 1'b0;
    end else begin
      ram_we  <= 1'b0;
      core_go <= 1'b0;

      if (rx_valid)
        gap_cnt <= '0;
      else if (state != IDLE)
        gap_cnt <= gap_cnt + GW'(1);

      // An arriving byte always wins over a timeout firing in the same cycle.
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= ADDR_LO;
              err   <= 1'b0;
              chk   <= 8'h00;
            end
          end
          ADDR_LO: begin
            addr_lo <= rx_data;
            chk     <= chk ^ rx_data;
            state   <= ADDR_HI;
          end
          ADDR_HI: begin
            wr_addr <= {rx_data[4:0], addr_lo};
            chk     <= chk ^ rx_data;
            state   <= CNT_LO;
          end
          CNT_LO: begin
            cnt_lo <= rx_data;
            chk    <= chk ^ rx_data;
            state  <= CNT_HI;
          end
          CNT_HI: begin
            words_left <= {rx_data, cnt_lo};
            byte_idx   <= 2'd0;
            chk        <= chk ^ rx_data;
            state      <= ({rx_data, cnt_lo} == 16'h0000) ? CHECK : DATA;
          end
          DATA: begin
            chk      <= chk ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              data_to_mem <= {rx_data, partial};
              ram_addres  <= wr_addr;
              ram_we      <= 1'b1;
              wr_addr     <= wr_addr + 13'd1;
              words_left  <= words_left - 16'd1;
              if (words_left == 16'd1)
                state <= CHECK;
            end else begin
              partial <= {rx_data, partial[23:8]};
            end
          end
          CHECK: begin
            if (rx_data == chk)
              core_go <= 1'b1;
            else
              err <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && gap_cnt == GW'(TIMEOUT_CYC - 1)) begin
        state    <= IDLE;
        err      <= 1'b1;
        byte_idx <= 2'd0;
        partial  <= 24'h000000;
        gap_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: good/bad checksum, address wrap, empty frame,
// inter-byte timeout and mid-frame reset, with a 40-cycle timeout configuration.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [12:0] ram_addres;
  logic [31:0] data_to_mem;
  logic        ram_we;
  logic        busy;
  logic        core_go;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int go_cnt = 0;
  int overlap = 0;

  uart_loader #(
    .CLK_FREQ  (1000000),
    .TIMEOUT_US(40),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ram_addres (ram_addres),
    .data_to_mem(data_to_mem),
    .ram_we     (ram_we),
    .busy       (busy),
    .core_go    (core_go),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (ram_we === 1'b1) we_cnt++;
    if (core_go === 1'b1) go_cnt++;
    if (ram_we === 1'b1 && core_go === 1'b1) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  initial begin
    logic [7:0] fr[$];
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_go", 32'(core_go), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(ram_addres), 32'd0);
    chk("rst_data", data_to_mem, 32'd0);
    rst = 1'b0;

    // Frame A: two words at 0x010, checksum 0x9A
    send(8'hA5);
    chk("a_busy", 32'(busy), 32'd1);
    fr = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_seq(fr);
    chk("a_we_early", 32'(ram_we), 32'd0);
    send(8'h44);
    chk("a_we0", 32'(ram_we), 32'd1);
    chk("a_addr0", 32'(ram_addres), 32'h010);
    chk("a_data0", data_to_mem, 32'h44332211);
    @(negedge clk);
    chk("a_we0_off", 32'(ram_we), 32'd0);
    fr = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_seq(fr);
    chk("a_we1", 32'(ram_we), 32'd1);
    chk("a_addr1", 32'(ram_addres), 32'h011);
    chk("a_data1", data_to_mem, 32'h88776655);
    send(8'h9A);
    chk("a_go", 32'(core_go), 32'd1);
    chk("a_err", 32'(err), 32'd0);
    chk("a_busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    chk("a_go_off", 32'(core_go), 32'd0);
    chk("a_we_cnt", we_cnt, 2);
    chk("a_go_cnt", go_cnt, 1);

    // Frame B: same payload, inverted checksum
    fr = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    send_seq(fr);
    @(negedge clk);
    chk("b_we_cnt", we_cnt, 4);
    chk("b_go_cnt", go_cnt, 1);
    chk("b_err", 32'(err), 32'd1);
    chk("b_busy", 32'(busy), 32'd0);
    send(8'h33);
    chk("b_err_sticky", 32'(err), 32'd1);
    chk("b_idle_noise", 32'(busy), 32'd0);

    // Frame C: address wrap 0x1FFF -> 0x0000, checksum 0xEA
    send(8'hA5);
    chk("c_err_clr", 32'(err), 32'd0);
    fr = '{8'hFF, 8'h1F, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(fr);
    chk("c_addr0", 32'(ram_addres), 32'h1FFF);
    chk("c_data0", data_to_mem, 32'h04030201);
    fr = '{8'h05, 8'h06, 8'h07, 8'h08};
    send_seq(fr);
    chk("c_addr1", 32'(ram_addres), 32'h0000);
    chk("c_data1", data_to_mem, 32'h08070605);
    send(8'hEA);
    chk("c_go", 32'(core_go), 32'd1);

    // Frame D: zero-length frame
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(fr);
    chk("d_go", 32'(core_go), 32'd1);
    chk("d_busy", 32'(busy), 32'd0);
    chk("d_we_cnt", we_cnt, 6);

    // Frame E: stall mid-word until the timeout fires, then a good frame
    fr = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send_seq(fr);
    chk("e_busy_mid", 32'(busy), 32'd1);
    repeat (60) @(negedge clk);
    chk("e_to_busy", 32'(busy), 32'd0);
    chk("e_to_err", 32'(err), 32'd1);
    chk("e_to_we_cnt", we_cnt, 6);
    fr = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_seq(fr);
    chk("e_we", 32'(ram_we), 32'd1);
    chk("e_addr", 32'(ram_addres), 32'h020);
    chk("e_data", data_to_mem, 32'hDDCCBBAA);
    send(8'h21);
    chk("e_go", 32'(core_go), 32'd1);
    chk("e_err", 32'(err), 32'd0);

    // Frame F: reset after the second data byte
    fr = '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send_seq(fr);
    #2 rst = 1'b1;
    #1;
    chk("f_busy", 32'(busy), 32'd0);
    chk("f_addr", 32'(ram_addres), 32'd0);
    chk("f_data", data_to_mem, 32'd0);
    chk("f_we", 32'(ram_we), 32'd0);
    chk("f_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fr = '{8'h33, 8'h44};
    send_seq(fr);
    repeat (3) @(negedge clk);
    chk("f_we_cnt", we_cnt, 7);
    chk("f_busy_after", 32'(busy), 32'd0);

    chk("go_total", go_cnt, 4);
    chk("we_go_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
